// File: rtl/design_variables.sv
// Shared widths, frame sizing helper and FSM state type for the max-result transmitter.
package design_variables;

  localparam int SCORE_WIDTH    = 10;
  localparam int ROW_BITS_WIDTH = 5;
  localparam int COL_BITS_WIDTH = 5;
  localparam int RESULT_WIDTH   = SCORE_WIDTH + ROW_BITS_WIDTH + COL_BITS_WIDTH;
  localparam int DEF_OUT_WIDTH  = 8;

  // Number of output words needed to carry RESULT_WIDTH bits at a given word width.
  function automatic int result_words(input int out_w);
    return (RESULT_WIDTH + out_w - 1) / out_w;
  endfunction

  localparam int RESULT_WORDS = result_words(DEF_OUT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/max_result_tx.sv
// Serialises {max_score, max_row, max_col} into OUT_WIDTH words, LSB word first.
// Optional MAX_TX_CHECKSUM_EN appends an XOR-of-data-words checksum as the final word.
module max_result_tx
  import design_variables::*;
#(
  parameter int OUT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_tx,
  input  logic [SCORE_WIDTH-1:0]    max_score,
  input  logic [ROW_BITS_WIDTH-1:0] max_row,
  input  logic [COL_BITS_WIDTH-1:0] max_col,
  output logic [OUT_WIDTH-1:0]      tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      tx_last,
  output logic                      busy,
  output logic                      tx_done
);

  localparam int NWORDS = result_words(OUT_WIDTH);
  localparam int PAD_W  = NWORDS * OUT_WIDTH;
  localparam int CNT_W  = $clog2(NWORDS + 1);
`ifdef MAX_TX_CHECKSUM_EN
  localparam int LAST_IDX = NWORDS;
`else
  localparam int LAST_IDX = NWORDS - 1;
`endif

  tx_state_e            state_q, state_d;
  logic [PAD_W-1:0]     frame_q, frame_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] word;
  logic                 at_last;

  always_comb begin
    word = '0;
    for (int k = 0; k < NWORDS; k++)
      if (cnt_q == CNT_W'(k)) word = frame_q[k*OUT_WIDTH +: OUT_WIDTH];
`ifdef MAX_TX_CHECKSUM_EN
    begin
      logic [OUT_WIDTH-1:0] csum;
      csum = '0;
      for (int k = 0; k < NWORDS; k++) csum = csum ^ frame_q[k*OUT_WIDTH +: OUT_WIDTH];
      if (cnt_q == CNT_W'(NWORDS)) word = csum;
    end
`endif
  end

  assign at_last  = (cnt_q == CNT_W'(LAST_IDX));
  assign tx_valid = (state_q == SEND);
  assign tx_data  = tx_valid ? word : '0;
  assign tx_last  = tx_valid && at_last;
  assign busy     = (state_q != IDLE);
  assign tx_done  = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (start_tx) begin
        frame_d = PAD_W'({max_score, max_row, max_col});
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: if (tx_ready) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (at_last) state_d = DONE;
      end
      // start_tx is deliberately not looked at here: a pulse in DONE is dropped.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_max_result_tx.sv
// Directed bench for max_result_tx; expected words are hand-computed constants.
module tb_max_result_tx;
  import design_variables::*;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      start_tx;
  logic [SCORE_WIDTH-1:0]    max_score;
  logic [ROW_BITS_WIDTH-1:0] max_row;
  logic [COL_BITS_WIDTH-1:0] max_col;
  logic [7:0]                tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic                      tx_last;
  logic                      busy;
  logic                      tx_done;

  int n_cmp = 0;
  int n_err = 0;

  // score=0x2A5,row=0x13,col=0x07 -> RESULT = 0x2A5<<10 | 0x13<<5 | 0x07 = 0xA9667
`ifdef MAX_TX_CHECKSUM_EN
  localparam int NW = 4;
  logic [7:0] exp_w [NW] = '{8'h67, 8'h96, 8'h0A, 8'hFB};  // 0x67^0x96^0x0A
`else
  localparam int NW = 3;
  logic [7:0] exp_w [NW] = '{8'h67, 8'h96, 8'h0A};
`endif

  max_result_tx #(.OUT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_tx(start_tx),
    .max_score(max_score), .max_row(max_row), .max_col(max_col),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".valid"}, 32'(tx_valid), 32'd0);
    chk({tag, ".data"},  32'(tx_data),  32'd0);
    chk({tag, ".last"},  32'(tx_last),  32'd0);
    chk({tag, ".busy"},  32'(busy),     32'd0);
    chk({tag, ".done"},  32'(tx_done),  32'd0);
  endtask

  task automatic load_inputs();
    max_score = 10'h2A5;
    max_row   = 5'h13;
    max_col   = 5'h07;
  endtask

  // Runs one frame from a start pulse; optional stall on one word, input scrubbing,
  // and stray start pulses in SEND and DONE.
  task automatic run_frame(input string tag, input int stall_word, input int stall_cyc,
                           input bit zero_inputs, input bit poke_start);
    load_inputs();
    start_tx = 1'b1;
    step();
    start_tx = 1'b0;
    if (zero_inputs) begin
      max_score = '0; max_row = '0; max_col = '0;
    end
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    for (int w = 0; w < NW; w++) begin
      if (w == stall_word) begin
        tx_ready = 1'b0;
        for (int s = 0; s < stall_cyc; s++) begin
          chk($sformatf("%s.stall%0d.valid", tag, s), 32'(tx_valid), 32'd1);
          chk($sformatf("%s.stall%0d.data", tag, s), 32'(tx_data), 32'(exp_w[w]));
          chk($sformatf("%s.stall%0d.last", tag, s), 32'(tx_last), 32'(w == NW - 1));
          step();
        end
        tx_ready = 1'b1;
      end
      chk($sformatf("%s.w%0d.valid", tag, w), 32'(tx_valid), 32'd1);
      chk($sformatf("%s.w%0d.data", tag, w), 32'(tx_data), 32'(exp_w[w]));
      chk($sformatf("%s.w%0d.last", tag, w), 32'(tx_last), 32'(w == NW - 1));
      chk($sformatf("%s.w%0d.done", tag, w), 32'(tx_done), 32'd0);
      if (poke_start && w == 1) start_tx = 1'b1;
      step();
      start_tx = 1'b0;
    end
    chk({tag, ".done"},      32'(tx_done),  32'd1);
    chk({tag, ".done.valid"}, 32'(tx_valid), 32'd0);
    chk({tag, ".done.data"},  32'(tx_data),  32'd0);
    chk({tag, ".done.busy"},  32'(busy),     32'd1);
    if (poke_start) start_tx = 1'b1;
    step();
    start_tx = 1'b0;
    chk_idle_outputs({tag, ".after"});
    step();
    chk_idle_outputs({tag, ".after2"});
  endtask

  initial begin
    rst_n = 1'b0; start_tx = 1'b0; tx_ready = 1'b1;
    max_score = '0; max_row = '0; max_col = '0;
    step();
    chk_idle_outputs("reset");
    start_tx = 1'b1;
    step();
    chk_idle_outputs("reset_start");
    start_tx = 1'b0;
    rst_n = 1'b1;
    step();
    chk_idle_outputs("idle");

    run_frame("basic", -1, 0, 1'b0, 1'b0);
    run_frame("stall", 1, 3, 1'b0, 1'b0);
    run_frame("stall_last", NW - 1, 2, 1'b0, 1'b0);
    run_frame("ignore_start", -1, 0, 1'b0, 1'b1);
    run_frame("scrub_inputs", -1, 0, 1'b1, 1'b0);

    // Reset after word 0 accepted: outputs drop, no done, next frame starts at word 0.
    load_inputs();
    start_tx = 1'b1;
    step();
    start_tx = 1'b0;
    chk("abort.w0", 32'(tx_data), 32'(exp_w[0]));
    step();
    chk("abort.w1", 32'(tx_data), 32'(exp_w[1]));
    rst_n = 1'b0;
    step();
    chk_idle_outputs("abort.rst");
    rst_n = 1'b1;
    step();
    chk_idle_outputs("abort.idle");
    run_frame("after_abort", -1, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
